noc_output_addr_fifo: RTL and testbench

//   Avalon-MM slave output port feeding a NoC address/destination channel; successor to the single 8-bit output register.
//   CPU writes are queued in a DEPTH-entry FIFO and drained to the NoC over an out_valid/out_ready handshake.

---
 rtl/noc_out_pkg.sv | 20 ++
 rtl/noc_out_sync_fifo.sv | 67 ++++++
 rtl/noc_output_addr_fifo.sv | 117 +++++++++++
 tb/tb_noc_output_addr_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_out_pkg.sv
// Shared register map and bit positions for the NoC output address FIFO.
// Used by noc_output_addr_fifo and its testbench.
package noc_out_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_IRQMSK = 2'd3
    } reg_sel_e;

    localparam int ST_EMPTY   = 16;
    localparam int ST_FULL    = 17;
    localparam int ST_OVF     = 18;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int IRQ_EMPTY  = 0;
    localparam int IRQ_OVF    = 1;

endpackage

// File: rtl/noc_out_sync_fifo.sv
// First-word-fall-through FIFO with flush; pushes on a full FIFO are accepted
// only when a pop frees a slot in the same cycle.
module noc_out_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) level_d = level_q + 1'b1;
            if (do_pop && !do_push) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/noc_output_addr_fifo.sv
// Avalon-MM slave that queues CPU writes and drains them to a NoC channel.
// Optional IRQMSK register and irq output enabled by defining NOC_OUT_IRQ_EN.
module noc_output_addr_fifo
    import noc_out_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);
    logic              wr_en, push, pop, flush, full, empty, ovf_set, ovf_clr;
    logic [LVL_W-1:0]  level;
    logic              en_q, en_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              unused_wd;

    assign wr_en   = chipselect & ~write_n;
    assign push    = wr_en & (address == REG_DATA);
    assign flush   = wr_en & (address == REG_CTRL) & writedata[CTRL_FLUSH];
    assign pop     = out_valid & out_ready;
    assign ovf_set = push & full & ~pop & ~flush;
    assign ovf_clr = wr_en & (address == REG_STATUS) & writedata[ST_OVF];
    assign unused_wd = ^writedata;

    noc_out_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .din_i   (writedata[DATA_W-1:0]),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (out_port),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_valid = ~empty & en_q;

    always_comb begin
        en_d   = en_q;
        last_d = last_q;
        ovf_d  = ovf_q;
        if (wr_en && address == REG_CTRL) en_d = writedata[CTRL_EN];
        if (push) last_d = writedata[DATA_W-1:0];
        // a set in the same cycle as a clear must win
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q   <= 1'b1;
            ovf_q  <= 1'b0;
            last_q <= '0;
        end else begin
            en_q   <= en_d;
            ovf_q  <= ovf_d;
            last_q <= last_d;
        end
    end

`ifdef NOC_OUT_IRQ_EN
    logic [1:0] msk_q, msk_d;
    logic       irq_q, irq_d;

    always_comb begin
        msk_d = msk_q;
        if (wr_en && address == REG_IRQMSK) msk_d = writedata[1:0];
        irq_d = (msk_q[IRQ_EMPTY] & empty & en_q) | (msk_q[IRQ_OVF] & ovf_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            msk_q <= '0;
            irq_q <= 1'b0;
        end else begin
            msk_q <= msk_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:   readdata = 32'(last_q);
            REG_STATUS: begin
                readdata[LVL_W-1:0] = level;
                readdata[ST_EMPTY]  = empty;
                readdata[ST_FULL]   = full;
                readdata[ST_OVF]    = ovf_q;
            end
            REG_CTRL:   readdata[CTRL_EN] = en_q;
`ifdef NOC_OUT_IRQ_EN
            REG_IRQMSK: readdata[1:0] = msk_q;
`endif
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_noc_output_addr_fifo.sv
// Randomized and directed bench for noc_output_addr_fifo against a queue-based
// reference model; honours NOC_OUT_IRQ_EN the same way as the design.
module tb_noc_output_addr_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        irq;

    int vecs = 0;
    int errs = 0;

    noc_output_addr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // reference model: a queue plus a few flags
    logic [7:0] mq[$];
    bit         m_en = 1'b1;
    bit         m_ovf = 1'b0;
    bit         m_irq = 1'b0;
    bit   [1:0] m_msk = 2'b00;
    logic [7:0] m_last = '0;

    always @(posedge clk) begin
        bit wr, pop, push, flush, ovf_set;
        int n;
        if (!reset_n) begin
            mq.delete();
            m_en   <= 1'b1;
            m_ovf  <= 1'b0;
            m_irq  <= 1'b0;
            m_msk  <= 2'b00;
            m_last <= '0;
        end else begin
            wr    = chipselect && !write_n;
            n     = mq.size();
            pop   = (n > 0) && m_en && out_ready;
            push  = wr && address == 2'd0;
            flush = wr && address == 2'd2 && writedata[1];
            ovf_set = 1'b0;
`ifdef NOC_OUT_IRQ_EN
            m_irq <= (m_msk[0] && n == 0 && m_en) || (m_msk[1] && m_ovf);
            if (wr && address == 2'd3) m_msk <= writedata[1:0];
`endif
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (n < DEPTH || pop) mq.push_back(writedata[7:0]);
                    else ovf_set = 1'b1;
                end
            end
            if (push) m_last <= writedata[7:0];
            if (wr && address == 2'd2) m_en <= writedata[0];
            if (ovf_set) m_ovf <= 1'b1;
            else if (wr && address == 2'd1 && writedata[18]) m_ovf <= 1'b0;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[7:0] = m_last;
            2'd1: begin
                r[2:0] = 3'(mq.size());
                r[16]  = (mq.size() == 0);
                r[17]  = (mq.size() == DEPTH);
                r[18]  = m_ovf;
            end
            2'd2: r[0] = m_en;
            default: begin
`ifdef NOC_OUT_IRQ_EN
                r[1:0] = m_msk;
`endif
            end
        endcase
        return r;
    endfunction

    // cycle-by-cycle comparison; inputs only change at negedge+1
    always @(negedge clk) begin
        logic       ev;
        logic [7:0] ep;
        logic [31:0] er;
        ev = (mq.size() > 0) && m_en;
        ep = (mq.size() > 0) ? mq[0] : 8'h00;
        er = exp_rd(address);
        vecs++;
        if (out_valid !== ev || out_port !== ep || readdata !== er || irq !== m_irq) begin
            errs++;
            $display("FAIL cycle t=%0t: valid %b/%b port %h/%h rd[%0d] %h/%h irq %b/%b (got/expected)",
                     $time, out_valid, ev, out_port, ep, address, readdata, er, irq, m_irq);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  seq3 [4];
        seq3[0] = 8'h02; seq3[1] = 8'h03; seq3[2] = 8'h04; seq3[3] = 8'h77;

        step(); step();
        reset_n = 1'b1;
        rd(2'd1, r); chk("rst_status", r, 32'h0001_0000);
        rd(2'd2, r); chk("rst_ctrl", r, 32'h1);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_port", 32'(out_port), 32'h0);

        // single write fall-through
        out_ready = 1'b1;
        wr(2'd0, 32'h5A);
        chk("fwft_port", 32'(out_port), 32'h5A);
        chk("fwft_valid", 32'(out_valid), 32'h1);
        step();
        chk("fwft_drained", 32'(out_valid), 32'h0);
        rd(2'd0, r); chk("last_wr", r, 32'h5A);

        // fill, overflow, drain
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(2'd0, 32'(i));
        rd(2'd1, r); chk("full_status", r, 32'h0002_0004);
        wr(2'd0, 32'h05);
        rd(2'd1, r); chk("ovf_status", r, 32'h0006_0004);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(out_port), 32'(i));
            step();
        end
        chk("drain_empty", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        wr(2'd1, 32'h0004_0000);
        rd(2'd1, r); chk("ovf_clear", r, 32'h0001_0000);

        // push on full with simultaneous pop
        for (int i = 1; i <= 4; i++) wr(2'd0, 32'(i));
        out_ready = 1'b1;
        wr(2'd0, 32'h77);
        for (int i = 0; i < 4; i++) begin
            chk("pushpop_order", 32'(out_port), 32'(seq3[i]));
            step();
        end
        rd(2'd1, r); chk("pushpop_no_ovf", r, 32'h0001_0000);
        out_ready = 1'b0;

        // disable holds entries, re-enable resumes
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h10);
        wr(2'd0, 32'h11);
        chk("dis_valid", 32'(out_valid), 32'h0);
        rd(2'd1, r); chk("dis_level", r, 32'h0000_0002);
        out_ready = 1'b1;
        wr(2'd2, 32'h1);
        chk("en_head0", 32'(out_port), 32'h10);
        step();
        chk("en_head1", 32'(out_port), 32'h11);
        step();
        chk("en_empty", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // flush
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h21 + 32'(i));
        wr(2'd2, 32'h3);
        rd(2'd1, r); chk("flush_status", r, 32'h0001_0000);
        chk("flush_valid", 32'(out_valid), 32'h0);
        rd(2'd2, r); chk("flush_ctrl", r, 32'h1);

`ifdef NOC_OUT_IRQ_EN
        wr(2'd3, 32'h2);
        for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i));
        chk("irq_lag", 32'(irq), 32'h0);
        step();
        chk("irq_ovf", 32'(irq), 32'h1);
        wr(2'd1, 32'h0004_0000);
        step();
        chk("irq_clr", 32'(irq), 32'h0);
        wr(2'd2, 32'h3);
        wr(2'd3, 32'h0);
`endif

        // reset with entries in flight
        wr(2'd0, 32'h42);
        wr(2'd0, 32'h43);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        rd(2'd1, r); chk("mid_rst_status", r, 32'h0001_0000);
        rd(2'd0, r); chk("mid_rst_last", r, 32'h0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 2) != 0);
            write_n    = ($urandom_range(0, 1) != 0);
            writedata  = $urandom;
            if (address == 2'd2) begin
                writedata[0] = ($urandom_range(0, 3) != 0);
                writedata[1] = ($urandom_range(0, 7) == 0);
            end
            out_ready  = ($urandom_range(0, 2) == 0);
            step();
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
